// File: rtl/pipe_status_unit.sv
// Y86 pipeline status/exception controller: registered status code, first-fault capture,
// RUN/DRAIN/STOPPED sequencing with restart and a saturating fault counter.
module pipe_status_unit #(
  parameter int unsigned ICODE_W      = 4,
  parameter int unsigned HALT_ICODE   = 0,
  parameter int unsigned PC_W         = 64,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [ICODE_W-1:0] icode,
  input  logic [PC_W-1:0]    pc,
  input  logic               memory_error,
  input  logic               instr_valid,
  input  logic               halt,
  input  logic               clear,
  output logic [2:0]         stat,
  output logic               running,
  output logic               stopped,
  output logic               commit_en,
  output logic [7:0]         drain_left,
  output logic [PC_W-1:0]    fault_pc,
  output logic [CNT_W-1:0]   exc_count
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_STOPPED = 2'd2} state_t;

  state_t           state_q;
  logic [2:0]       stat_q;
  logic             running_q;
  logic             stopped_q;
  logic [7:0]       drain_left_q;
  logic [PC_W-1:0]  fault_pc_q;
  logic [CNT_W-1:0] exc_count_q;

  logic             fault;
  logic [2:0]       cause;
  logic [CNT_W-1:0] exc_count_d;

  always_comb begin
    fault = valid && (memory_error || !instr_valid || halt || (icode == ICODE_W'(HALT_ICODE)));
    if (memory_error) begin
      cause = STAT_ADR;
    end else if (!instr_valid) begin
      cause = STAT_INS;
    end else begin
      cause = STAT_HLT;
    end
    exc_count_d = (&exc_count_q) ? exc_count_q : exc_count_q + CNT_W'(1);
  end

  // DRAIN only counts down; causes and clear are not sampled there, so the first fault wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      stat_q       <= STAT_AOK;
      running_q    <= 1'b1;
      stopped_q    <= 1'b0;
      drain_left_q <= 8'd0;
      fault_pc_q   <= '0;
      exc_count_q  <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fault) begin
            stat_q      <= cause;
            fault_pc_q  <= pc;
            exc_count_q <= exc_count_d;
            running_q   <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              state_q      <= ST_STOPPED;
              stopped_q    <= 1'b1;
              drain_left_q <= 8'd0;
            end else begin
              state_q      <= ST_DRAIN;
              drain_left_q <= 8'(DRAIN_CYCLES);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_left_q <= 8'd1) begin
            state_q      <= ST_STOPPED;
            stopped_q    <= 1'b1;
            drain_left_q <= 8'd0;
          end else begin
            drain_left_q <= drain_left_q - 8'd1;
          end
        end
        ST_STOPPED: begin
          if (clear) begin
            state_q   <= ST_RUN;
            stat_q    <= STAT_AOK;
            running_q <= 1'b1;
            stopped_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          stat_q       <= STAT_AOK;
          running_q    <= 1'b1;
          stopped_q    <= 1'b0;
          drain_left_q <= 8'd0;
        end
      endcase
    end
  end

  // Only combinational output: a halting instruction still commits, ADR/INS ones do not.
  assign commit_en  = running_q && !(valid && (memory_error || !instr_valid));
  assign stat       = stat_q;
  assign running    = running_q;
  assign stopped    = stopped_q;
  assign drain_left = drain_left_q;
  assign fault_pc   = fault_pc_q;
  assign exc_count  = exc_count_q;

endmodule

// File: tb/tb_pipe_status_unit.sv
// Bench for pipe_status_unit: two instances (4-cycle drain / 8-bit count, no drain / 2-bit count)
// share stimulus and are compared against a cycle-arithmetic reference model.
module tb_pipe_status_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, memory_error, instr_valid, halt, clear;
  logic [3:0]  icode;
  logic [63:0] pc;

  logic [1:0][2:0]  stat_v;
  logic [1:0]       running_v, stopped_v, commit_v;
  logic [1:0][7:0]  drain_v;
  logic [1:0][63:0] fpc_v;
  logic [7:0]       cnt_a;
  logic [1:0]       cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model per instance: fault time plus captured values
  int          drain_n [2] = '{4, 0};
  int          cnt_max [2] = '{255, 3};
  bit          m_faulted [2];
  int          m_t [2];
  logic [2:0]  m_stat [2];
  logic [63:0] m_fpc [2];
  int          m_cnt [2];

  always #5 clk = ~clk;

  pipe_status_unit #(.DRAIN_CYCLES(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .valid(valid), .icode(icode), .pc(pc),
    .memory_error(memory_error), .instr_valid(instr_valid), .halt(halt), .clear(clear),
    .stat(stat_v[0]), .running(running_v[0]), .stopped(stopped_v[0]), .commit_en(commit_v[0]),
    .drain_left(drain_v[0]), .fault_pc(fpc_v[0]), .exc_count(cnt_a)
  );

  pipe_status_unit #(.DRAIN_CYCLES(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .valid(valid), .icode(icode), .pc(pc),
    .memory_error(memory_error), .instr_valid(instr_valid), .halt(halt), .clear(clear),
    .stat(stat_v[1]), .running(running_v[1]), .stopped(stopped_v[1]), .commit_en(commit_v[1]),
    .drain_left(drain_v[1]), .fault_pc(fpc_v[1]), .exc_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int k);
    return (k == 0) ? {56'd0, cnt_a} : {62'd0, cnt_b};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_faulted[k] = 1'b0;
      m_t[k]       = 0;
      m_stat[k]    = 3'd1;
      m_fpc[k]     = 64'd0;
      m_cnt[k]     = 0;
    end
  endtask

  task automatic check_all();
    int kk;
    int exp_drain;
    bit exp_stop;
    bit exp_commit;
    for (int k = 0; k < 2; k++) begin
      kk = cyc - m_t[k];
      exp_drain = 0;
      exp_stop  = 1'b0;
      if (m_faulted[k]) begin
        if (kk <= drain_n[k]) exp_drain = drain_n[k] - kk + 1;
        else exp_stop = 1'b1;
      end
      exp_commit = !m_faulted[k] && !(valid && (memory_error || !instr_valid));
      chk($sformatf("stat%0d", k),    64'(stat_v[k]),    64'(m_stat[k]));
      chk($sformatf("running%0d", k), 64'(running_v[k]), 64'(!m_faulted[k]));
      chk($sformatf("stopped%0d", k), 64'(stopped_v[k]), 64'(exp_stop));
      chk($sformatf("drain%0d", k),   64'(drain_v[k]),   64'(exp_drain));
      chk($sformatf("fpc%0d", k),     fpc_v[k],          m_fpc[k]);
      chk($sformatf("cnt%0d", k),     cnt_of(k),         64'(m_cnt[k]));
      chk($sformatf("commit%0d", k),  64'(commit_v[k]),  64'(exp_commit));
    end
  endtask

  task automatic model_edge();
    bit f;
    f = valid && (memory_error || !instr_valid || halt || icode == 4'd0);
    for (int k = 0; k < 2; k++) begin
      if (!m_faulted[k]) begin
        if (f) begin
          m_faulted[k] = 1'b1;
          m_t[k]       = cyc;
          m_stat[k]    = memory_error ? 3'd3 : (!instr_valid ? 3'd4 : 3'd2);
          m_fpc[k]     = pc;
          m_cnt[k]     = (m_cnt[k] < cnt_max[k]) ? m_cnt[k] + 1 : cnt_max[k];
        end
      end else if ((cyc - m_t[k] > drain_n[k]) && clear) begin
        m_faulted[k] = 1'b0;
        m_stat[k]    = 3'd1;
      end
    end
  endtask

  // called at a negedge with inputs already set; returns at the next negedge
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    valid = 1'b0; memory_error = 1'b0; instr_valid = 1'b1; halt = 1'b0;
    clear = 1'b0; icode = 4'd3; pc = 64'd0;
  endtask

  task automatic set_instr(input logic [3:0] ic, input logic [63:0] p, input logic me,
                           input logic iv, input logic h);
    valid = 1'b1; icode = ic; pc = p; memory_error = me; instr_valid = iv; halt = h;
  endtask

  int seq [5] = '{1, 2, 3, 3, 3};

  initial begin
    idle_in();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_stat", 64'(stat_v[0]), 64'd1);

    // steady run of non-faulting instructions
    set_instr(4'd3, 64'h100, 1'b0, 1'b1, 1'b0);
    repeat (10) tick();

    // ADR fault with every cause raised
    set_instr(4'd3, 64'h40, 1'b1, 1'b0, 1'b1);
    #1;
    chk("adr_commit_T", 64'(commit_v[0]), 64'd0);
    tick();
    chk("adr_stat", 64'(stat_v[0]), 64'd3);
    chk("adr_fpc", fpc_v[0], 64'h40);
    chk("adr_cnt", 64'(cnt_a), 64'd1);
    chk("adr_drain", 64'(drain_v[0]), 64'd4);
    set_instr(4'd0, 64'h80, 1'b0, 1'b1, 1'b0);
    tick();
    idle_in();
    repeat (3) tick();
    chk("drain_fpc_kept", fpc_v[0], 64'h40);
    chk("stopped_T5", 64'(stopped_v[0]), 64'd1);

    // restart, then halt icode is accepted and still commits
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("restart_stat", 64'(stat_v[0]), 64'd1);
    chk("restart_run", 64'(running_v[0]), 64'd1);
    set_instr(4'd0, 64'h10, 1'b0, 1'b1, 1'b0);
    #1;
    chk("hlt_commit_T", 64'(commit_v[0]), 64'd1);
    tick();
    chk("hlt_stat", 64'(stat_v[0]), 64'd2);
    chk("hlt_fpc", fpc_v[0], 64'h10);
    chk("hlt_cnt", 64'(cnt_a), 64'd2);
    idle_in();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      valid        = ($urandom_range(0, 3) != 0);
      icode        = 4'($urandom_range(0, 15));
      pc           = {$urandom, $urandom};
      memory_error = ($urandom_range(0, 15) == 0);
      instr_valid  = ($urandom_range(0, 15) != 0);
      halt         = ($urandom_range(0, 15) == 0);
      clear        = ($urandom_range(0, 3) == 0);
      tick();
    end

    // asynchronous reset in the middle of DRAIN
    idle_in();
    clear = 1'b1;
    repeat (6) tick();
    clear = 1'b0;
    set_instr(4'd5, 64'h77, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_stat", 64'(stat_v[0]), 64'd1);
    chk("arst_run", 64'(running_v[0]), 64'd1);
    chk("arst_drain", 64'(drain_v[0]), 64'd0);
    chk("arst_fpc", fpc_v[0], 64'd0);
    chk("arst_cnt", 64'(cnt_a), 64'd0);
    check_all();
    #1;
    rst = 1'b0;
    @(negedge clk);
    tick();

    // zero-drain instance: halt/clear rounds with a saturating 2-bit count
    for (int r = 0; r < 5; r++) begin
      set_instr(4'd0, 64'(r * 16), 1'b0, 1'b1, 1'b0);
      tick();
      chk($sformatf("round%0d_stopped", r), 64'(stopped_v[1]), 64'd1);
      chk($sformatf("round%0d_cnt", r), 64'(cnt_b), 64'(seq[r]));
      idle_in();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk($sformatf("round%0d_run", r), 64'(running_v[1]), 64'd1);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
